cmsdk_mybusmatrix_slave_port_arbiter: RTL and testbench

//  Round-robin arbiter for one bus-matrix slave port shared by NUM_MASTERS input stages.

---
 rtl/cmsdk_mybusmatrix_slave_port_arbiter.sv | 106 ++++++++++
 tb/tb_cmsdk_mybusmatrix_slave_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_mybusmatrix_slave_port_arbiter.sv
//==============================================================================
// Module   : cmsdk_mybusmatrix_slave_port_arbiter
// Purpose  : Round-robin owner arbiter for one shared bus-matrix slave port,
//            producing address-phase and data-phase mux selects.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmsdk_mybusmatrix_slave_port_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int ID_W        = 2
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic [NUM_MASTERS-1:0]   req,
   input  logic [2*NUM_MASTERS-1:0] htrans,
   input  logic [NUM_MASTERS-1:0]   hmastlock,
   input  logic                     HREADY,
   output logic [NUM_MASTERS-1:0]   addr_sel,
   output logic [ID_W-1:0]          addr_id,
   output logic                     no_port,
   output logic [NUM_MASTERS-1:0]   data_sel,
   output logic                     data_valid
);

   typedef enum logic [0:0] {
      S_NOPORT = 1'b0,
      S_OWNED  = 1'b1
   } state_t;

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;

   logic [1:0]        w_own_htrans;
   logic              w_own_lock;
   logic              w_hold;
   logic              w_own_active;
   logic              w_found;
   logic [ID_W-1:0]   w_winner;

   // addr_id doubles as the current owner index while in S_OWNED
   always_comb begin
      w_own_htrans = 2'b00;
      w_own_lock   = 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (addr_id == ID_W'(m)) begin
            w_own_htrans = htrans[2*m +: 2];
            w_own_lock   = hmastlock[m];
         end
      end
   end

   assign w_hold       = (r_state == S_OWNED) &&
                         ((w_own_htrans == 2'b11) || (w_own_htrans == 2'b01) || w_own_lock);
   assign w_own_active = (r_state == S_OWNED) && w_own_htrans[1];

   // Rotation starts after rr_ptr, so the last winner is considered last
   always_comb begin : p_search
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         v_idx = int'(r_rr_ptr) + i;
         if (v_idx >= NUM_MASTERS) begin
            v_idx = v_idx - NUM_MASTERS;
         end
         if (!w_found && req[v_idx[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = v_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state    <= S_NOPORT;
         r_rr_ptr   <= ID_W'(NUM_MASTERS-1);
         addr_sel   <= '0;
         addr_id    <= '0;
         no_port    <= 1'b1;
         data_sel   <= '0;
         data_valid <= 1'b0;
      end else if (HREADY) begin
         data_valid <= w_own_active;
         data_sel   <= w_own_active ? (NUM_MASTERS'(1) << addr_id) : '0;
         if (!w_hold) begin
            if (w_found) begin
               r_state  <= S_OWNED;
               r_rr_ptr <= w_winner;
               addr_sel <= NUM_MASTERS'(1) << w_winner;
               addr_id  <= w_winner;
               no_port  <= 1'b0;
            end else begin
               r_state  <= S_NOPORT;
               addr_sel <= '0;
               addr_id  <= '0;
               no_port  <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmsdk_mybusmatrix_slave_port_arbiter.sv
//==============================================================================
// Module   : tb_cmsdk_mybusmatrix_slave_port_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a queue-free
//            integer model of the round-robin slave-port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cmsdk_mybusmatrix_slave_port_arbiter;

   localparam int N = 3;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic [N-1:0]   req;
   logic [2*N-1:0] htrans;
   logic [N-1:0]   hmastlock;
   logic           HREADY;
   logic [N-1:0]   addr_sel;
   logic [1:0]     addr_id;
   logic           no_port;
   logic [N-1:0]   data_sel;
   logic           data_valid;

   int checks = 0;
   int errors = 0;

   // Model: owner index (-1 = none), rotation pointer, data-phase owner
   int m_owner, m_ptr, m_dsel;
   bit m_dv;

   cmsdk_mybusmatrix_slave_port_arbiter #(.NUM_MASTERS(N), .ID_W(2)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .req(req), .htrans(htrans),
      .hmastlock(hmastlock), .HREADY(HREADY), .addr_sel(addr_sel),
      .addr_id(addr_id), .no_port(no_port), .data_sel(data_sel),
      .data_valid(data_valid)
   );

   always #5 HCLK = ~HCLK;

   function automatic void model_step();
      logic [1:0] ht;
      int nd, nw;
      bit hold;
      if (HRESET) begin
         m_owner = -1; m_ptr = N-1; m_dsel = -1; m_dv = 0;
      end else if (HREADY) begin
         nd = -1; hold = 0;
         if (m_owner >= 0) begin
            ht   = htrans[2*m_owner +: 2];
            if (ht[1]) nd = m_owner;
            hold = (ht == T_SEQ) || (ht == T_BUSY) || hmastlock[m_owner];
         end
         if (!hold) begin
            nw = -1;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (nw < 0 && req[c]) nw = c;
            end
            if (nw >= 0) m_ptr = nw;
            m_owner = nw;
         end
         m_dsel = nd;
         m_dv   = (nd >= 0);
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HRESET = 1; HREADY = 1; req = 3'b111; hmastlock = '0;
      htrans = {T_NSEQ, T_NSEQ, T_NSEQ};
      tick();
      checks++; if (addr_sel !== 3'b000) begin errors++; $display("FAIL reset_addr_sel got %b exp 000", addr_sel); end
      checks++; if (addr_id !== 2'd0) begin errors++; $display("FAIL reset_addr_id got %0d exp 0", addr_id); end
      checks++; if (no_port !== 1'b1) begin errors++; $display("FAIL reset_no_port got %b exp 1", no_port); end
      checks++; if (data_sel !== 3'b000 || data_valid !== 1'b0) begin errors++; $display("FAIL reset_data got %b/%b exp 000/0", data_sel, data_valid); end
      HRESET = 0;
      tick();
      checks++; if (addr_sel !== 3'b001 || addr_id !== 2'd0 || no_port !== 1'b0) begin errors++; $display("FAIL first_grant got %b/%0d/%b exp 001/0/0", addr_sel, addr_id, no_port); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL first_grant_dv got %b exp 0", data_valid); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] one;
      one = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (addr_sel !== (one << ((i+1)%3)) || addr_id !== 2'((i+1)%3)) begin errors++; $display("FAIL rr_owner step %0d got %b/%0d exp %b", i, addr_sel, addr_id, one << ((i+1)%3)); end
         checks++; if (data_sel !== (one << i) || data_valid !== 1'b1) begin errors++; $display("FAIL rr_data step %0d got %b/%b exp %b/1", i, data_sel, data_valid, one << i); end
      end
   endtask

   task automatic test_burst();
      tick();
      checks++; if (addr_sel !== 3'b010) begin errors++; $display("FAIL burst_start got %b exp 010", addr_sel); end
      htrans = {T_NSEQ, T_SEQ, T_NSEQ};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (addr_sel !== 3'b010 || data_sel !== 3'b010 || data_valid !== 1'b1) begin errors++; $display("FAIL burst_hold beat %0d got %b/%b/%b exp 010/010/1", i, addr_sel, data_sel, data_valid); end
      end
      htrans = {T_NSEQ, T_IDLE, T_NSEQ}; req = 3'b101;
      tick();
      checks++; if (addr_sel !== 3'b100 || data_valid !== 1'b0) begin errors++; $display("FAIL burst_end got %b/%b exp 100/0", addr_sel, data_valid); end
   endtask

   task automatic test_hready_stall();
      req = 3'b010; htrans = {T_IDLE, T_NSEQ, T_IDLE};
      tick();
      checks++; if (addr_sel !== 3'b010) begin errors++; $display("FAIL stall_grant got %b exp 010", addr_sel); end
      htrans = {T_IDLE, T_SEQ, T_IDLE};
      tick();
      HREADY = 0; req = 3'b111; htrans = {T_NSEQ, T_SEQ, T_NSEQ};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (addr_sel !== 3'b010 || data_sel !== 3'b010 || data_valid !== 1'b1) begin errors++; $display("FAIL stall_frozen cyc %0d got %b/%b/%b exp 010/010/1", i, addr_sel, data_sel, data_valid); end
      end
      HREADY = 1;
      tick();
      checks++; if (addr_sel !== 3'b010) begin errors++; $display("FAIL stall_resume got %b exp 010", addr_sel); end
      htrans = {T_NSEQ, T_NSEQ, T_NSEQ};
      tick();
      checks++; if (addr_sel !== 3'b100) begin errors++; $display("FAIL stall_handover got %b exp 100", addr_sel); end
   endtask

   task automatic test_lock();
      req = 3'b001; htrans = {T_IDLE, T_IDLE, T_NSEQ}; hmastlock = 3'b001;
      tick();
      checks++; if (addr_sel !== 3'b001) begin errors++; $display("FAIL lock_grant got %b exp 001", addr_sel); end
      htrans = {T_IDLE, T_IDLE, T_IDLE}; req = 3'b010;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (addr_sel !== 3'b001 || data_valid !== 1'b0) begin errors++; $display("FAIL lock_hold cyc %0d got %b/%b exp 001/0", i, addr_sel, data_valid); end
      end
      hmastlock = 3'b000;
      tick();
      checks++; if (addr_sel !== 3'b010 || addr_id !== 2'd1) begin errors++; $display("FAIL lock_release got %b/%0d exp 010/1", addr_sel, addr_id); end
   endtask

   task automatic test_reset_mid_burst();
      htrans = {T_IDLE, T_SEQ, T_IDLE}; req = 3'b010;
      tick();
      HREADY = 0; HRESET = 1;
      tick();
      checks++; if (no_port !== 1'b1 || addr_sel !== 3'b000 || addr_id !== 2'd0) begin errors++; $display("FAIL midreset_addr got %b/%b/%0d exp 1/000/0", no_port, addr_sel, addr_id); end
      checks++; if (data_valid !== 1'b0 || data_sel !== 3'b000) begin errors++; $display("FAIL midreset_data got %b/%b exp 0/000", data_valid, data_sel); end
      HRESET = 0; HREADY = 1; req = 3'b111; htrans = {T_NSEQ, T_NSEQ, T_NSEQ};
      tick();
      checks++; if (addr_sel !== 3'b001) begin errors++; $display("FAIL midreset_first got %b exp 001", addr_sel); end
   endtask

   task automatic test_random();
      logic [N-1:0] one, exp_as, exp_ds;
      one = 1;
      for (int i = 0; i < 600; i++) begin
         HRESET = ($urandom_range(0, 80) == 0);
         HREADY = ($urandom_range(0, 3) != 0);
         req    = N'($urandom);
         htrans = (2*N)'($urandom);
         for (int m = 0; m < N; m++) hmastlock[m] = ($urandom_range(0, 7) == 0);
         tick();
         exp_as = (m_owner < 0) ? '0 : (one << m_owner);
         exp_ds = (m_dsel  < 0) ? '0 : (one << m_dsel);
         checks++; if (addr_sel !== exp_as || no_port !== (m_owner < 0)) begin errors++; $display("FAIL rand_addr cyc %0d got %b/%b exp %b/%b", i, addr_sel, no_port, exp_as, m_owner < 0); end
         checks++; if (addr_id !== 2'((m_owner < 0) ? 0 : m_owner)) begin errors++; $display("FAIL rand_id cyc %0d got %0d exp %0d", i, addr_id, (m_owner < 0) ? 0 : m_owner); end
         checks++; if (data_sel !== exp_ds || data_valid !== m_dv) begin errors++; $display("FAIL rand_data cyc %0d got %b/%b exp %b/%b", i, data_sel, data_valid, exp_ds, m_dv); end
      end
   endtask

   initial begin
      m_owner = -1; m_ptr = N-1; m_dsel = -1; m_dv = 0;
      test_reset();
      test_round_robin();
      test_burst();
      test_hready_stall();
      test_lock();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
